// File: rtl/mem_burst_reader.sv
// Burst reader: fetches up to 16 consecutive 16-bit words from a synchronous memory into a 256-bit word.
// Optional macro MEM_READ_PIPELINE_EN issues one read per cycle instead of one read every two cycles.
module mem_burst_reader (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic [15:0]  address,
    input  logic [15:0]  len,
    output logic [255:0] q,
    output logic         done,
    output logic         busy,
    output logic         mem_rd_en,
    output logic [15:0]  mem_addr,
    input  logic [15:0]  mem_rdata
);

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned MAX_WORDS = 16;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned Q_W       = DATA_W * MAX_WORDS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic [Q_W-1:0]     q_q,         q_d;
    logic               done_q,      done_d;
    logic               busy_q,      busy_d;
    logic               rd_en_q,     rd_en_d;
    logic [ADDR_W-1:0]  addr_q,      addr_d;
    logic [CNT_W-1:0]   n_q,         n_d;
    logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]   rcv_cnt_q,   rcv_cnt_d;
    logic               valid_q,     valid_d;

    logic [CNT_W-1:0]   eff_n_c;
    logic [7:0]         word_lsb_c;
    logic               last_c;

    // Clamp the requested length to the 16-word capacity of q.
    always_comb begin
        if (len == 16'd0) begin
            eff_n_c = CNT_W'(0);
        end else if (len > 16'(MAX_WORDS)) begin
            eff_n_c = CNT_W'(MAX_WORDS);
        end else begin
            eff_n_c = len[CNT_W-1:0];
        end
    end

    assign word_lsb_c = {4'd15 - rcv_cnt_q[3:0], 4'd0};
    assign last_c     = (CNT_W'(rcv_cnt_q + CNT_W'(1)) == n_q);

    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        done_d      = done_q;
        busy_d      = busy_q;
        rd_en_d     = rd_en_q;
        addr_d      = addr_q;
        n_d         = n_q;
        issue_cnt_d = issue_cnt_q;
        rcv_cnt_d   = rcv_cnt_q;
        valid_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = READ;
                    q_d         = '0;
                    done_d      = 1'b0;
                    busy_d      = 1'b1;
                    n_d         = eff_n_c;
                    rcv_cnt_d   = CNT_W'(0);
                    issue_cnt_d = CNT_W'(0);
                    if (eff_n_c != CNT_W'(0)) begin
                        rd_en_d     = 1'b1;
                        addr_d      = address;
                        issue_cnt_d = CNT_W'(1);
                    end
                end
            end

            READ: begin
                if (!start) begin
                    // Abort: in-flight data is dropped because valid_d stays 0.
                    state_d = IDLE;
                    rd_en_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end else if (n_q == CNT_W'(0)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    valid_d = rd_en_q;
`ifdef MEM_READ_PIPELINE_EN
                    if (issue_cnt_q < n_q) begin
                        rd_en_d     = 1'b1;
                        addr_d      = ADDR_W'(addr_q + ADDR_W'(1));
                        issue_cnt_d = CNT_W'(issue_cnt_q + CNT_W'(1));
                    end else begin
                        rd_en_d = 1'b0;
                    end
`else
                    if (valid_q && !last_c) begin
                        rd_en_d     = 1'b1;
                        addr_d      = ADDR_W'(addr_q + ADDR_W'(1));
                        issue_cnt_d = CNT_W'(issue_cnt_q + CNT_W'(1));
                    end else begin
                        rd_en_d = 1'b0;
                    end
`endif
                    if (valid_q) begin
                        q_d[word_lsb_c +: DATA_W] = mem_rdata;
                        rcv_cnt_d = CNT_W'(rcv_cnt_q + CNT_W'(1));
                        if (last_c) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            rd_en_d = 1'b0;
                            valid_d = 1'b0;
                        end
                    end
                end
            end

            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                rd_en_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            q_q         <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            n_q         <= '0;
            issue_cnt_q <= '0;
            rcv_cnt_q   <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            rd_en_q     <= rd_en_d;
            addr_q      <= addr_d;
            n_q         <= n_d;
            issue_cnt_q <= issue_cnt_d;
            rcv_cnt_q   <= rcv_cnt_d;
            valid_q     <= valid_d;
        end
    end

    assign q         = q_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign mem_rd_en = rd_en_q;
    assign mem_addr  = addr_q;

endmodule

// File: tb/tb_mem_burst_reader.sv
// Bench for mem_burst_reader: table of bursts checked against a word model, plus abort and reset sequences.
module tb_mem_burst_reader;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [15:0]  address = 16'd0;
    logic [15:0]  len = 16'd0;
    logic [255:0] q;
    logic         done;
    logic         busy;
    logic         mem_rd_en;
    logic [15:0]  mem_addr;
    logic [15:0]  mem_rdata = 16'd0;

    int asserts = 0;
    int fails   = 0;
    int rd_count = 0;
    logic [15:0] exp_addr_q[$];

    typedef struct {
        logic [15:0] addr;
        logic [15:0] len;
        int          hold;
    } vec_t;

    vec_t vecs[7];

    mem_burst_reader dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .address   (address),
        .len       (len),
        .q         (q),
        .done      (done),
        .busy      (busy),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    // Synchronous memory model: word i holds 0x1000+i.
    always @(posedge clock) begin
        if (mem_rd_en) mem_rdata <= 16'(16'h1000 + mem_addr);
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every issued read is matched against the next expected address.
    always @(negedge clock) begin
        if (reset_n && mem_rd_en) begin
            rd_count++;
            if (exp_addr_q.size() == 0) begin
                asserts++;
                fails++;
                $display("FAIL unexpected_read: addr %h with no read expected at %0t", mem_addr, $time);
            end else begin
                check("rd_addr", 256'(mem_addr), 256'(exp_addr_q.pop_front()));
            end
        end
    end

    function automatic logic [15:0] word_of(input logic [15:0] a);
        logic [15:0] w;
        w = 16'(16'h1000 + a);
        return w;
    endfunction

    task automatic run_burst(input logic [15:0] a, input logic [15:0] l, input int hold);
        int n;
        int exp_edge;
        int edge_i;
        bit got;
        logic [255:0] exp_q;
        logic [15:0] ak;
        n = (l == 16'd0) ? 0 : ((l > 16'd16) ? 16 : int'(l));
        exp_q = '0;
        for (int k = 0; k < n; k++) begin
            ak = 16'(a + 16'(k));
            exp_q[(15 - k) * 16 +: 16] = word_of(ak);
            exp_addr_q.push_back(ak);
        end
`ifdef MEM_READ_PIPELINE_EN
        exp_edge = (n == 0) ? 1 : n + 1;
`else
        exp_edge = (n == 0) ? 1 : 2 * n;
`endif
        @(negedge clock);
        rd_count = 0;
        start = 1'b1;
        address = a;
        len = l;
        edge_i = -1;
        got = 1'b0;
        for (int e = 0; e < 40 && !got; e++) begin
            @(posedge clock);
            #1;
            if (e == 0) begin
                check("busy_start", 256'(busy), 256'(1'b1));
                address = ~a;
                len = 16'd3;
            end
            if (done) begin
                got = 1'b1;
                edge_i = e;
            end
        end
        check("done_edge", 256'(edge_i), 256'(exp_edge));
        check("busy_at_done", 256'(busy), 256'(1'b0));
        check("q_at_done", q, exp_q);
        for (int h = 0; h < hold; h++) begin
            @(posedge clock);
            #1;
            check("done_hold", 256'(done), 256'(1'b1));
        end
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        #1;
        check("done_clear", 256'(done), 256'(1'b0));
        check("q_retained", q, exp_q);
        check("reads_left", 256'(exp_addr_q.size()), 256'(0));
        check("read_count", 256'(rd_count), 256'(n));
    endtask

    initial begin
        vecs[0] = '{addr: 16'h0010, len: 16'd4,  hold: 0};
        vecs[1] = '{addr: 16'h0000, len: 16'd40, hold: 2};
        vecs[2] = '{addr: 16'hFFFE, len: 16'd4,  hold: 0};
        vecs[3] = '{addr: 16'h0000, len: 16'd0,  hold: 1};
        vecs[4] = '{addr: 16'h0100, len: 16'd16, hold: 5};
        vecs[5] = '{addr: 16'h0200, len: 16'd1,  hold: 0};
        vecs[6] = '{addr: 16'h0300, len: 16'd17, hold: 0};

        // Reset state, checked while reset is still applied.
        repeat (2) @(negedge clock);
        check("rst_q", q, 256'd0);
        check("rst_done", 256'(done), 256'd0);
        check("rst_busy", 256'(busy), 256'd0);
        check("rst_rd_en", 256'(mem_rd_en), 256'd0);
        check("rst_mem_addr", 256'(mem_addr), 256'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 7; i++) begin
            run_burst(vecs[i].addr, vecs[i].len, vecs[i].hold);
        end

        // Abort after two words of a len=8 burst.
        begin
            bit seen;
            logic [255:0] exp_q;
            for (int k = 0; k < 8; k++) exp_addr_q.push_back(16'(16'h0020 + 16'(k)));
            exp_q = '0;
            exp_q[255:240] = 16'h1020;
            exp_q[239:224] = 16'h1021;
            @(negedge clock);
            start = 1'b1;
            address = 16'h0020;
            len = 16'd8;
            seen = 1'b0;
            for (int e = 0; e < 40 && !seen; e++) begin
                @(posedge clock);
                #1;
                if (q[239:224] != 16'd0) seen = 1'b1;
            end
            check("abort_word1_seen", 256'(seen), 256'(1'b1));
            @(negedge clock);
            start = 1'b0;
            @(posedge clock);
            #1;
            check("abort_rd_en", 256'(mem_rd_en), 256'd0);
            check("abort_busy", 256'(busy), 256'd0);
            check("abort_done", 256'(done), 256'd0);
            check("abort_q", q, exp_q);
            exp_addr_q.delete();
            repeat (4) @(posedge clock);
            #1;
            check("abort_idle_done", 256'(done), 256'd0);
            check("abort_idle_q", q, exp_q);
        end

        // Asynchronous reset in the middle of a burst.
        for (int k = 0; k < 8; k++) exp_addr_q.push_back(16'(16'h0040 + 16'(k)));
        @(negedge clock);
        start = 1'b1;
        address = 16'h0040;
        len = 16'd8;
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_rd_en", 256'(mem_rd_en), 256'd0);
        check("mid_rst_busy", 256'(busy), 256'd0);
        check("mid_rst_done", 256'(done), 256'd0);
        check("mid_rst_q", q, 256'd0);
        check("mid_rst_mem_addr", 256'(mem_addr), 256'd0);
        start = 1'b0;
        exp_addr_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("post_rst_done", 256'(done), 256'd0);

        run_burst(16'h0050, 16'd2, 0);

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
